// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending CPU stores drained in program order to
// memory, with per-byte forwarding of buffered data to loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        cpu_stall,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wpc,
    input  logic        mem_wready,
    output logic        buf_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  be_q   [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic [AW-1:0] head, tail, idx;
    logic [AW:0]   count;
    logic          store_req, enq, deq, full;
    logic          unused_lsb;

    assign store_req = (m_data_byteen != 4'b0000);
    assign full      = (count == FULL);
    assign enq       = store_req && !full;
    assign deq       = mem_wready && (count != '0);
    assign cpu_stall = store_req && full;
    assign buf_empty = (count == '0);
    assign unused_lsb = ^m_data_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            // simultaneous enq/deq leaves count unchanged
            if (enq && !deq)      count <= count + 1'b1;
            else if (!enq && deq) count <= count - 1'b1;
        end
    end

    // Entry payload needs no reset; validity is tracked by head/count only.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= m_data_addr[31:2];
            data_q[tail] <= m_data_wdata;
            be_q[tail]   <= m_data_byteen;
            pc_q[tail]   <= m_inst_addr;
        end
    end

    assign mem_waddr  = {addr_q[head], 2'b00};
    assign mem_wdata  = data_q[head];
    assign mem_wpc    = pc_q[head];
    assign mem_byteen = buf_empty ? 4'b0000 : be_q[head];
    assign mem_raddr  = {m_data_addr[31:2], 2'b00};

    // Walk valid entries oldest to newest so the newest match per lane wins.
    // The store being enqueued this cycle is not yet in the array.
    always_comb begin
        m_data_rdata = mem_rdata;
        idx          = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (((AW+1)'(i) < count) && (addr_q[idx] == m_data_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[idx][b]) m_data_rdata[8*b +: 8] = data_q[idx][8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboard of expected memory writes,
// checked by a negedge monitor, plus direct checks of stall/forward/reset.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic        cpu_stall;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata, mem_wpc;
    logic [3:0]  mem_byteen;
    logic        mem_wready, buf_empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc;
    } wr_t;
    wr_t sb[$];

    int pass_cnt = 0;
    int total    = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .m_data_rdata(m_data_rdata), .cpu_stall(cpu_stall),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_wpc(mem_wpc),
        .mem_wready(mem_wready), .buf_empty(buf_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] pc);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        m_inst_addr   = pc;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] pc);
        wr_t w;
        w.addr = {a[31:2], 2'b00};
        w.data = d;
        w.be   = be;
        w.pc   = pc;
        sb.push_back(w);
    endtask

    task automatic drain(input string tag);
        m_data_byteen = 4'b0000;
        mem_wready    = 1'b1;
        for (int i = 0; i < 20 && !buf_empty; i++) tick();
        #1;
        chk(tag, {31'd0, buf_empty}, 32'd1);
    endtask

    // A head write presented with mem_wready high completes at the next edge.
    always @(negedge clk) begin
        if (!reset && mem_wready && mem_byteen != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_be", {28'd0, mem_byteen}, 32'd0);
            end else begin
                wr_t w;
                w = sb.pop_front();
                chk("wr_addr", mem_waddr, w.addr);
                chk("wr_data", mem_wdata, w.data);
                chk("wr_be",   {28'd0, mem_byteen}, {28'd0, w.be});
                chk("wr_pc",   mem_wpc, w.pc);
            end
        end
    end

    initial begin
        int mcount, sent;
        logic acc, wr;
        reset = 1'b1;
        mem_wready = 1'b0;
        mem_rdata = 32'h55667788;
        drive(32'h23, 32'h0, 4'b0000, 32'h0);
        #12;
        chk("rst_byteen", {28'd0, mem_byteen}, 32'd0);
        chk("rst_empty", {31'd0, buf_empty}, 32'd1);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_rdata", m_data_rdata, 32'h55667788);
        chk("raddr_align", mem_raddr, 32'h20);
        tick();
        reset = 1'b0;

        // single store
        mem_wready = 1'b1;
        drive(32'h10, 32'hAABBCCDD, 4'hF, 32'h3000);
        push(32'h10, 32'hAABBCCDD, 4'hF, 32'h3000);
        tick();
        m_data_byteen = 4'b0000;
        #1;
        chk("s1_waddr", mem_waddr, 32'h10);
        chk("s1_be", {28'd0, mem_byteen}, 32'hF);
        chk("s1_pc", mem_wpc, 32'h3000);
        tick();
        chk("s1_empty", {31'd0, buf_empty}, 32'd1);

        // fill and stall
        mem_wready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(32'h100 + 4*k, 32'hA0000000 + k, 4'hF, 32'h4000 + 4*k);
            #1;
            chk("s2_nostall", {31'd0, cpu_stall}, 32'd0);
            push(32'h100 + 4*k, 32'hA0000000 + k, 4'hF, 32'h4000 + 4*k);
            tick();
        end
        drive(32'h110, 32'hA0000004, 4'hF, 32'h4010);
        #1;
        chk("s2_stall5", {31'd0, cpu_stall}, 32'd1);
        tick();
        chk("s2_stall_hold", {31'd0, cpu_stall}, 32'd1);
        mem_wready = 1'b1;
        #1;
        chk("s2_stall_wready", {31'd0, cpu_stall}, 32'd1);
        tick();
        chk("s2_accept5", {31'd0, cpu_stall}, 32'd0);
        push(32'h110, 32'hA0000004, 4'hF, 32'h4010);
        tick();
        drain("s2_drained");

        // byte forwarding and exclusion of the enqueuing store
        mem_wready = 1'b0;
        mem_rdata  = 32'h11223344;
        drive(32'h20, 32'h000000EE, 4'b0001, 32'h5000);
        push(32'h20, 32'h000000EE, 4'b0001, 32'h5000);
        tick();
        drive(32'h20, 32'hBEEF0000, 4'b1100, 32'h5004);
        push(32'h20, 32'hBEEF0000, 4'b1100, 32'h5004);
        tick();
        m_data_byteen = 4'b0000;
        #1;
        chk("s3_fwd", m_data_rdata, 32'hBEEF33EE);
        drive(32'h20, 32'h000000AA, 4'b0001, 32'h5008);
        #1;
        chk("s3_excl_enq", m_data_rdata, 32'hBEEF33EE);
        push(32'h20, 32'h000000AA, 4'b0001, 32'h5008);
        tick();
        m_data_byteen = 4'b0000;
        #1;
        chk("s3_newest_byte", m_data_rdata, 32'hBEEF33AA);
        m_data_addr = 32'h24;
        #1;
        chk("s3_miss", m_data_rdata, 32'h11223344);
        m_data_addr = 32'h20;
        mem_wready  = 1'b1;
        #1;
        chk("s3_fwd_deq_head", m_data_rdata, 32'hBEEF33AA);
        drain("s3_drained");
        chk("s3_after_drain", m_data_rdata, 32'h11223344);

        // newest wins
        mem_wready = 1'b0;
        drive(32'h40, 32'h1, 4'hF, 32'h5100);
        push(32'h40, 32'h1, 4'hF, 32'h5100);
        tick();
        drive(32'h40, 32'h2, 4'hF, 32'h5104);
        push(32'h40, 32'h2, 4'hF, 32'h5104);
        tick();
        m_data_byteen = 4'b0000;
        #1;
        chk("s4_two", m_data_rdata, 32'h2);
        mem_wready = 1'b1;
        tick();
        chk("s4_one", m_data_rdata, 32'h2);
        tick();
        chk("s4_none", m_data_rdata, 32'h11223344);
        chk("s4_empty", {31'd0, buf_empty}, 32'd1);

        // simultaneous enqueue/dequeue at count 2
        mem_wready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(32'h80 + 4*k, 32'hB0 + k, 4'hF, 32'h5200 + 4*k);
            push(32'h80 + 4*k, 32'hB0 + k, 4'hF, 32'h5200 + 4*k);
            tick();
        end
        drive(32'h88, 32'hB2, 4'hF, 32'h5208);
        push(32'h88, 32'hB2, 4'hF, 32'h5208);
        mem_wready = 1'b1;
        tick();
        m_data_byteen = 4'b0000;
        tick();
        chk("s5_cnt_a", {31'd0, buf_empty}, 32'd0);
        tick();
        chk("s5_cnt_b", {31'd0, buf_empty}, 32'd1);

        // ten stores with sparse wready: fills, stalls and wraps the pointers
        mcount = 0;
        sent   = 0;
        for (int k = 0; k < 60 && sent < 10; k++) begin
            wr = (k % 4 == 3);
            mem_wready = wr;
            drive(32'h200 + 4*sent, 32'hC0DE0000 + sent, 4'hF, 32'h6000 + 4*sent);
            acc = (mcount < DEPTH);
            #1;
            chk("s5_stall", {31'd0, cpu_stall}, {31'd0, !acc});
            if (acc) begin
                push(32'h200 + 4*sent, 32'hC0DE0000 + sent, 4'hF, 32'h6000 + 4*sent);
                sent++;
            end
            mcount = mcount + (acc ? 1 : 0) - ((wr && mcount > 0) ? 1 : 0);
            tick();
        end
        chk("s5_sent", sent, 10);
        drain("s5_drained");

        // reset mid-drain discards pending stores
        mem_wready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(32'h300 + 4*k, 32'hD0 + k, 4'hF, 32'h7000 + 4*k);
            tick();
        end
        m_data_byteen = 4'b0000;
        #1;
        chk("s6_held", {31'd0, buf_empty}, 32'd0);
        reset = 1'b1;
        #1;
        chk("s6_rst_be", {28'd0, mem_byteen}, 32'd0);
        chk("s6_rst_empty", {31'd0, buf_empty}, 32'd1);
        tick();
        reset = 1'b0;
        mem_wready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("s6_no_stale_be", {28'd0, mem_byteen}, 32'd0);
        chk("s6_empty", {31'd0, buf_empty}, 32'd1);
        chk("sb_left", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
